// File: rtl/aclock_set_ctrl_if.sv
// Bundle between the setting controller, the button front end and the alarm-clock core.
// The controller uses the slave side; the driver of buttons and core values uses the master side.
interface aclock_set_ctrl_if;
  logic       tick_1s;
  logic       mode_btn;
  logic       inc_btn;
  logic       cancel_btn;
  logic       target_sel;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0;
  logic [3:0] cur_m1;
  logic [3:0] cur_m0;
  logic [1:0] H_in1;
  logic [3:0] H_in0;
  logic [3:0] M_in1;
  logic [3:0] M_in0;
  logic       LD_time;
  logic       LD_alarm;
  logic       set_active;
  logic [1:0] edit_field;

  modport slave (
    input  tick_1s, mode_btn, inc_btn, cancel_btn, target_sel,
    input  cur_h1, cur_h0, cur_m1, cur_m0,
    output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, set_active, edit_field
  );

  modport master (
    output tick_1s, mode_btn, inc_btn, cancel_btn, target_sel,
    output cur_h1, cur_h0, cur_m1, cur_m0,
    input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, set_active, edit_field
  );
endinterface

// File: rtl/aclock_set_ctrl.sv
// Push-button time/alarm setting controller: BCD edit registers, auto-repeat, edit timeout,
// and a load request held across exactly one core 1 Hz sampling edge.
module aclock_set_ctrl #(
  parameter int REPEAT_DLY  = 16,
  parameter int REPEAT_RATE = 4,
  parameter int TIMEOUT_S   = 30
) (
  input  logic             clk,
  input  logic             reset,
  aclock_set_ctrl_if.slave bus
);
  localparam int RW = $clog2(REPEAT_DLY + 1);
  localparam int TW = $clog2(TIMEOUT_S + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EDIT_H = 2'd1;
  localparam logic [1:0] EDIT_M = 2'd2;
  localparam logic [1:0] LOAD   = 2'd3;

  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DLY - REPEAT_RATE);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_S);

  logic [1:0]    state_q, state_d;
  logic          target_q, target_d;
  logic [2:0]    btn_hist_q;
  logic [2:0]    btn_lvl, btn_edge;
  logic [1:0]    h1_q, h1_d, sh_h1_q, sh_h1_d;
  logic [3:0]    h0_q, h0_d, sh_h0_q, sh_h0_d;
  logic [3:0]    m1_q, m1_d, sh_m1_q, sh_m1_d;
  logic [3:0]    m0_q, m0_d, sh_m0_q, sh_m0_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          ld_time_q, ld_time_d, ld_alarm_q, ld_alarm_d;
  logic          mode_edge, inc_edge, cancel_edge, any_edge, bump;

  // Bit order {cancel, inc, mode}; history resets high so a held button needs a fresh press.
  assign btn_lvl = {bus.cancel_btn, bus.inc_btn, bus.mode_btn};
  for (genvar gi = 0; gi < 3; gi++) begin : g_edge
    assign btn_edge[gi] = btn_lvl[gi] & ~btn_hist_q[gi];
  end
  assign mode_edge   = btn_edge[0];
  assign inc_edge    = btn_edge[1];
  assign cancel_edge = btn_edge[2];
  assign any_edge    = |btn_edge;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    h1_d       = h1_q;
    h0_d       = h0_q;
    m1_d       = m1_q;
    m0_d       = m0_q;
    sh_h1_d    = sh_h1_q;
    sh_h0_d    = sh_h0_q;
    sh_m1_d    = sh_m1_q;
    sh_m0_d    = sh_m0_q;
    rpt_d      = '0;
    tmo_d      = '0;
    ld_time_d  = ld_time_q;
    ld_alarm_d = ld_alarm_q;
    bump       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_edge) begin
          target_d = bus.target_sel;
          if (bus.target_sel) begin
            {h1_d, h0_d, m1_d, m0_d} = {sh_h1_q, sh_h0_q, sh_m1_q, sh_m0_q};
          end else begin
            {h1_d, h0_d, m1_d, m0_d} = {bus.cur_h1, bus.cur_h0, bus.cur_m1, bus.cur_m0};
          end
          state_d = EDIT_H;
        end
      end
      EDIT_H, EDIT_M: begin
        if (any_edge)
          tmo_d = '0;
        else if (bus.tick_1s && tmo_q != TMO_MAX)
          tmo_d = tmo_q + TW'(1);
        else
          tmo_d = tmo_q;
        // rpt_q counts cycles inc has been held; the press cycle itself is the first.
        if (inc_edge)
          rpt_d = RW'(1);
        else if (bus.inc_btn)
          rpt_d = (rpt_q == RPT_FIRE) ? RPT_RELOAD : rpt_q + RW'(1);
        if (cancel_edge)
          state_d = IDLE;
        else if (mode_edge)
          state_d = (state_q == EDIT_H) ? EDIT_M : LOAD;
        else if (tmo_q == TMO_MAX)
          state_d = IDLE;
        else
          bump = inc_edge || (bus.inc_btn && rpt_q == RPT_FIRE);
        if (state_d != state_q) begin
          rpt_d = '0;
          tmo_d = '0;
        end
      end
      LOAD: begin
        if (!ld_time_q && !ld_alarm_q) begin
          ld_time_d  = ~target_q;
          ld_alarm_d = target_q;
        end else if (bus.tick_1s) begin
          ld_time_d  = 1'b0;
          ld_alarm_d = 1'b0;
          state_d    = IDLE;
          if (target_q)
            {sh_h1_d, sh_h0_d, sh_m1_d, sh_m0_d} = {h1_q, h0_q, m1_q, m0_q};
        end
      end
      default: state_d = IDLE;
    endcase

    if (bump && state_q == EDIT_H) begin
      if (h1_q == 2'd2 && h0_q == 4'd3) begin
        h1_d = 2'd0;
        h0_d = 4'd0;
      end else if (h0_q == 4'd9) begin
        h1_d = h1_q + 2'd1;
        h0_d = 4'd0;
      end else begin
        h0_d = h0_q + 4'd1;
      end
    end else if (bump && state_q == EDIT_M) begin
      if (m1_q == 4'd5 && m0_q == 4'd9) begin
        m1_d = 4'd0;
        m0_d = 4'd0;
      end else if (m0_q == 4'd9) begin
        m1_d = m1_q + 4'd1;
        m0_d = 4'd0;
      end else begin
        m0_d = m0_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      target_q   <= 1'b0;
      btn_hist_q <= 3'b111;
      {h1_q, h0_q, m1_q, m0_q}         <= '0;
      {sh_h1_q, sh_h0_q, sh_m1_q, sh_m0_q} <= '0;
      rpt_q      <= '0;
      tmo_q      <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      btn_hist_q <= btn_lvl;
      {h1_q, h0_q, m1_q, m0_q}         <= {h1_d, h0_d, m1_d, m0_d};
      {sh_h1_q, sh_h0_q, sh_m1_q, sh_m0_q} <= {sh_h1_d, sh_h0_d, sh_m1_d, sh_m0_d};
      rpt_q      <= rpt_d;
      tmo_q      <= tmo_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
    end
  end

  assign bus.H_in1      = h1_q;
  assign bus.H_in0      = h0_q;
  assign bus.M_in1      = m1_q;
  assign bus.M_in0      = m0_q;
  assign bus.LD_time    = ld_time_q;
  assign bus.LD_alarm   = ld_alarm_q;
  assign bus.set_active = (state_q != IDLE);
  assign bus.edit_field = (state_q == EDIT_H) ? 2'd1 :
                          (state_q == EDIT_M) ? 2'd2 : 2'd0;
endmodule

// File: tb/tb_aclock_set_ctrl.sv
// Randomized bench for aclock_set_ctrl: an hours/minutes arithmetic model predicts each load
// request, which a monitor checks when the DUT raises LD_time or LD_alarm.
module tb_aclock_set_ctrl;
  localparam int DLY = 16, RATE = 4, TMO = 30;
  localparam int P_IDLE = 0, P_H = 1, P_M = 2, P_LOAD = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aclock_set_ctrl_if bus();
  aclock_set_ctrl #(.REPEAT_DLY(DLY), .REPEAT_RATE(RATE), .TIMEOUT_S(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_cmp = 0, n_bad = 0;

  typedef struct { bit alarm; int hh; int mm; int len; } ld_t;
  ld_t exp_q[$];

  // Reference model: whole hours/minutes as integers, phase of the edit session.
  int m_phase = P_IDLE, m_h = 0, m_m = 0, sh_h = 0, sh_m = 0, cur_h = 0, cur_m = 0, m_idle = 0;
  bit m_tgt = 1'b0;

  // Monitor state.
  bit mon_in = 1'b0, mon_kind = 1'b0, mon_bad = 1'b0;
  int mon_len = 0, mon_hv = 0, mon_mv = 0, n_txn = 0;

  function automatic int bcd(input int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_h = 0; m_m = 0; sh_h = 0; sh_m = 0; m_idle = 0;
  endfunction

  task automatic drive_cur(input int hh, input int mm);
    cur_h = hh; cur_m = mm;
    bus.cur_h1 = 2'(hh / 10); bus.cur_h0 = 4'(hh % 10);
    bus.cur_m1 = 4'(mm / 10); bus.cur_m0 = 4'(mm % 10);
  endtask

  task automatic chk_view(input string tag);
    chk({tag, ".field"}, int'(bus.edit_field), (m_phase == P_H) ? 1 : (m_phase == P_M) ? 2 : 0);
    chk({tag, ".active"}, int'(bus.set_active), (m_phase != P_IDLE) ? 1 : 0);
    chk({tag, ".hours"}, int'({bus.H_in1, bus.H_in0}), bcd(m_h));
    chk({tag, ".mins"}, int'({bus.M_in1, bus.M_in0}), bcd(m_m));
  endtask

  task automatic pulse(input bit m, input bit i, input bit c);
    bus.mode_btn = m; bus.inc_btn = i; bus.cancel_btn = c;
    @(negedge clk);
    bus.mode_btn = 1'b0; bus.inc_btn = 1'b0; bus.cancel_btn = 1'b0;
    @(negedge clk);
  endtask

  function automatic void add_incs(input int k);
    if (m_phase == P_H) m_h = (m_h + k) % 24;
    else if (m_phase == P_M) m_m = (m_m + k) % 60;
  endfunction

  task automatic do_mode();
    if (m_phase == P_IDLE) begin
      m_tgt = bus.target_sel;
      m_h = m_tgt ? sh_h : cur_h;
      m_m = m_tgt ? sh_m : cur_m;
      m_phase = P_H;
    end else if (m_phase == P_H) begin
      m_phase = P_M;
    end
    m_idle = 0;
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_inc();
    add_incs(1);
    m_idle = 0;
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  // Held n cycles: one step on press, one at DLY cycles held, then one per RATE cycles.
  task automatic hold_inc(input int n);
    add_incs(1 + ((n >= DLY) ? 1 + (n - DLY) / RATE : 0));
    m_idle = 0;
    bus.inc_btn = 1'b1;
    repeat (n) @(negedge clk);
    bus.inc_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_cancel(input bit with_mode);
    if (m_phase == P_H || m_phase == P_M) m_phase = P_IDLE;
    pulse(with_mode, 1'b0, 1'b1);
  endtask

  task automatic tick_pulse();
    if (m_phase == P_H || m_phase == P_M) begin
      m_idle++;
      if (m_idle == TMO) m_phase = P_IDLE;
    end
    bus.tick_1s = 1'b1;
    @(negedge clk);
    bus.tick_1s = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_exp(input int len);
    ld_t e;
    e.alarm = m_tgt; e.hh = m_h; e.mm = m_m; e.len = len;
    exp_q.push_back(e);
  endtask

  // From EDIT_M: mode press, d cycles of random (ignored) buttons, then one tick_1s.
  task automatic commit(input int d, input bit early_tick);
    push_exp(d + 1);
    bus.mode_btn = 1'b1;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    bus.tick_1s = early_tick;
    @(negedge clk);
    bus.tick_1s = 1'b0;
    repeat (d) begin
      bus.mode_btn = 1'($urandom_range(0, 1));
      bus.inc_btn = 1'($urandom_range(0, 1));
      bus.cancel_btn = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.mode_btn = 1'b0; bus.inc_btn = 1'b0; bus.cancel_btn = 1'b0;
    bus.tick_1s = 1'b1;
    @(negedge clk);
    bus.tick_1s = 1'b0;
    @(negedge clk);
    m_phase = P_IDLE;
    if (m_tgt) begin sh_h = m_h; sh_m = m_m; end
  endtask

  task automatic rnd_inc();
    if ($urandom_range(0, 1) == 0) do_inc();
    else hold_inc(int'($urandom_range(2, 40)));
  endtask

  // Monitor: one LD pulse is one transaction, compared against the head of the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.LD_time || bus.LD_alarm) begin
        if (!mon_in) begin
          mon_in = 1'b1; mon_len = 0; mon_bad = 1'b0; mon_kind = bus.LD_alarm;
          mon_hv = int'({bus.H_in1, bus.H_in0}); mon_mv = int'({bus.M_in1, bus.M_in0});
        end
        mon_len++;
        if (bus.LD_time && bus.LD_alarm) mon_bad = 1'b1;
        if (bus.LD_alarm != mon_kind) mon_bad = 1'b1;
        if (int'({bus.H_in1, bus.H_in0}) != mon_hv || int'({bus.M_in1, bus.M_in0}) != mon_mv)
          mon_bad = 1'b1;
      end else if (mon_in) begin
        ld_t e;
        mon_in = 1'b0;
        n_txn++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ld.unexpected: got pulse kind %0d len %0d, expected none", mon_kind, mon_len);
        end else begin
          e = exp_q.pop_front();
          chk("ld.kind", int'(mon_kind), int'(e.alarm));
          chk("ld.hours", mon_hv, bcd(e.hh));
          chk("ld.mins", mon_mv, bcd(e.mm));
          chk("ld.len", mon_len, e.len);
          chk("ld.clean", int'(mon_bad), 0);
          $display("txn %0d: %s load %02h:%02h held %0d cycles (want %s %02h:%02h for %0d)",
                   n_txn, mon_kind ? "alarm" : "time", mon_hv, mon_mv, mon_len,
                   e.alarm ? "alarm" : "time", bcd(e.hh), bcd(e.mm), e.len);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, expected completion within 5 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tick_1s = 1'b0; bus.inc_btn = 1'b0; bus.cancel_btn = 1'b0;
    bus.mode_btn = 1'b1; bus.target_sel = 1'b0;
    drive_cur(9, 58);
    model_reset();
    #1;
    chk_view("reset");
    chk("reset.ld_time", int'(bus.LD_time), 0);
    chk("reset.ld_alarm", int'(bus.LD_alarm), 0);

    // Mode held through reset release gives no edge.
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk_view("held_mode");
    bus.mode_btn = 1'b0;
    @(negedge clk);
    do_mode();
    chk_view("enter_after_release");

    // 09:58 time target: +15 hours, +3 minutes -> 00:01.
    repeat (15) do_inc();
    chk_view("hours_wrap");
    do_mode();
    repeat (3) do_inc();
    chk_view("mins_wrap");
    commit(3, 1'b1);
    chk_view("after_time_load");

    // Alarm target 06:30 from the reset shadow, then re-enter to see the preload.
    bus.target_sel = 1'b1;
    do_mode();
    bus.target_sel = 1'b0;
    repeat (6) do_inc();
    do_mode();
    repeat (30) do_inc();
    chk_view("alarm_edit");
    commit(5, 1'b0);
    bus.target_sel = 1'b1;
    do_mode();
    chk_view("alarm_preload");
    do_cancel(1'b0);
    chk_view("cancel_h");
    do_inc();
    do_cancel(1'b0);
    chk_view("idle_ignores");

    // Auto-repeat: 28 cycles held from 07 -> 12, nothing more after release.
    bus.target_sel = 1'b0;
    drive_cur(7, 15);
    do_mode();
    hold_inc(DLY + 3 * RATE);
    chk_view("repeat_hold");
    repeat (10) @(negedge clk);
    chk_view("repeat_release");

    // Mode and cancel together in EDIT_M.
    do_mode();
    do_cancel(1'b1);
    chk_view("mode_cancel");

    // Timeout in EDIT_H after TMO ticks, not before.
    do_mode();
    repeat (TMO - 1) tick_pulse();
    chk_view("timeout_minus1");
    tick_pulse();
    chk_view("timeout");

    // Reset while LD_time is high.
    drive_cur(13, 44);
    do_mode();
    do_inc();
    do_mode();
    push_exp(3);
    bus.mode_btn = 1'b1;
    @(negedge clk);
    bus.mode_btn = 1'b0;
    @(negedge clk);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort.ld_time", int'(bus.LD_time), 0);
    chk("abort.ld_alarm", int'(bus.LD_alarm), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk_view("abort_after");
    bus.target_sel = 1'b1;
    do_mode();
    chk_view("abort_shadow");
    do_cancel(1'b0);

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      drive_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      bus.target_sel = 1'($urandom_range(0, 1));
      do_mode();
      bus.target_sel = 1'($urandom_range(0, 1));
      drive_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
      chk_view("rnd_enter");
      repeat ($urandom_range(0, 3)) rnd_inc();
      if ($urandom_range(0, 9) == 0) begin
        do_cancel(1'b0);
        chk_view("rnd_cancel_h");
        continue;
      end
      do_mode();
      repeat ($urandom_range(0, 3)) rnd_inc();
      chk_view("rnd_edit_m");
      if ($urandom_range(0, 4) == 0) begin
        do_cancel(1'b0);
        chk_view("rnd_cancel_m");
      end else begin
        commit(int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        chk_view("rnd_commit");
      end
    end

    repeat (3) @(negedge clk);
    chk("end.queue_empty", exp_q.size(), 0);
    chk("end.no_open_pulse", int'(mon_in), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aclock_set_ctrl.md
Name: aclock_set_ctrl

Overview:
- Push-button setting controller for the alarm-clock core.
- Turns debounced MODE/INC/CANCEL buttons and a target selector into digit values on the core's H_in*/M_in* buses, plus a LD_time or LD_alarm request.
- Holds each load request until the core's 1 Hz sampling edge has passed.
- Keeps a shadow copy of the committed alarm time so alarm editing starts from the current alarm.

Parameters:
- REPEAT_DLY, 16: clk cycles INC must be held before auto-repeat starts.
- REPEAT_RATE, 4: clk cycles between auto-repeat increments.
- TIMEOUT_S, 30: tick_1s pulses with no button edge before an edit is abandoned.

Ports:
- clk  in  1  system clock; same clock that drives the core.
- reset  in  1  asynchronous, active-low reset.
- tick_1s  in  1  one-clk pulse coincident with the core's 1 Hz rising edge.
- mode_btn  in  1  debounced level; rising edge = enter/advance.
- inc_btn  in  1  debounced level; rising edge or hold = increment the field.
- cancel_btn  in  1  debounced level; rising edge = abandon the edit.
- target_sel  in  1  0 = set time, 1 = set alarm; sampled on entry only.
- cur_h1  in  2  current hours tens from the core.
- cur_h0, cur_m1, cur_m0  in  4 each  current hours ones / minutes tens / minutes ones from the core.
- H_in1  out  2  hours tens to the core.
- H_in0, M_in1, M_in0  out  4 each  hours ones / minutes tens / minutes ones to the core.
- LD_time  out  1  time load request.
- LD_alarm  out  1  alarm load request.
- set_active  out  1  high in any state other than IDLE.
- edit_field  out  2  0 = none, 1 = hours, 2 = minutes.

Behaviour:
- Reset (async, reset=0):
  - All outputs 0; state IDLE.
  - Edit registers 00:00; alarm shadow 00:00 (matches the core's alarm reset).
  - Repeat and timeout counters 0.
  - Button-history flops reset to 1, so a button held through reset gives no edge until it is released and pressed again.
- Edge detection: press = level 1 this cycle and 0 in the history flop. All decisions act on registered edges.
- Priority in one cycle: cancel > mode > inc.
- FSM states: IDLE, EDIT_H, EDIT_M, LOAD.
- IDLE:
  - On mode edge, latch target_sel.
  - Preload edit registers from cur_* (time target) or from the alarm shadow (alarm target).
  - Go to EDIT_H.
  - inc and cancel are ignored.
- EDIT_H: inc steps hours in BCD 00..23.
  - h0 9→0 with h1+1.
  - 23→00 wrap.
  - mode edge → EDIT_M.
- EDIT_M: inc steps minutes in BCD 00..59.
  - m0 9→0 with m1+1.
  - 59→00 wrap; no carry into hours.
  - mode edge → LOAD.
- Auto-repeat (EDIT_H/EDIT_M):
  - Counter clears on the inc edge.
  - Once inc has been held REPEAT_DLY cycles, one extra increment fires, then one more every REPEAT_RATE cycles while inc stays high.
  - Counter clears on inc release and on any state change.
- Timeout (EDIT_H/EDIT_M):
  - Counter counts tick_1s and clears on any button edge.
  - Reaching TIMEOUT_S → IDLE with no load.
- Cancel edge in EDIT_H/EDIT_M → IDLE with no load. Edit registers keep their values; LD stays 0.
- LOAD:
  - Assert LD_time (target 0) or LD_alarm (target 1) starting the cycle after entry.
  - The selected LD stays high until the first tick_1s seen while it is asserted.
  - It drops on the following cycle; state → IDLE. The request therefore covers exactly one core sampling edge.
  - On the alarm target, the alarm shadow updates from the edit registers when LD drops.
  - All buttons are ignored in LOAD.
- H_in*/M_in* always drive the edit registers. They are stable for the entire LD pulse; edits are impossible in LOAD.
- LD_time and LD_alarm are never high together.
- edit_field: 1 in EDIT_H, 2 in EDIT_M, 0 otherwise.
- Reset mid-LOAD: LD drops asynchronously; alarm shadow is not updated.
- Widths: internal BCD digits use the output widths. Counters are sized ceil(log2(param+1)); no overflow past the threshold.

Test Plan:
- Reset with mode_btn held high, then release and press mode → no edge while held; after release and press, EDIT_H, set_active=1, edit_field=1.
- cur=09:58, target_sel=0; mode, inc×15, mode, inc×3, mode → H_in=00, M_in=01 (09+15 wraps past 23 to 00; 58+3 wraps past 59 to 01). LD_time high from 1 cycle after entering LOAD until 1 cycle after tick_1s, then 0, state IDLE.
- target_sel=1, set 06:30 and commit → LD_alarm pulse only, LD_time stays 0. Re-enter with target_sel=1 → edit registers preload 06:30.
- EDIT_H, inc held 16+4×3 cycles from 07 → 1 + 1 + 3 = 5 increments → 12; after release no further increments.
- EDIT_M, mode and cancel edges in the same cycle → IDLE, no LD. EDIT_H idle for 30 tick_1s → IDLE, no LD.
- In LOAD pull reset low before tick_1s → LD_time=0 immediately, IDLE; alarm shadow unchanged.
